// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, iteration count, FSM states.
package md_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/md_iter.sv
// One radix-2 step on magnitudes: shift-add multiply, or restoring divide when MD_DIV_EN is defined.
// {hi,lo} is the partial product / {remainder,dividend-quotient} pair; purely combinational.
module md_iter (
`ifdef MD_DIV_EN
    input  logic        is_div,
`endif
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    logic [32:0] sum;
`ifdef MD_DIV_EN
    logic [32:0] shl;
    logic        borrow;
    logic [31:0] rem_sub;
`endif

    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b_in} : 33'd0);
        hi_out = sum[32:1];
        lo_out = {sum[0], lo_in[31:1]};
`ifdef MD_DIV_EN
        shl     = {hi_in, lo_in[31]};
        borrow  = shl < {1'b0, b_in};
        // On success the true difference is below the divisor, so 32 bits suffice.
        rem_sub = shl[31:0] - b_in;
        if (is_div) begin
            if (borrow) begin
                hi_out = shl[31:0];
                lo_out = {lo_in[30:0], 1'b0};
            end else begin
                hi_out = rem_sub;
                lo_out = {lo_in[30:0], 1'b1};
            end
        end
`endif
    end

endmodule

// File: rtl/md_ctrl.sv
// Iterative MIPS-style mult/div unit with HI/LO: 34-cycle start-to-visible latency, stalls EX users while busy.
// Divide support is built only when MD_DIV_EN is defined; otherwise divide starts are ignored.
module md_ctrl
    import md_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        startE,
    input  logic [1:0]  mdOpE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    input  logic        mfE,
    input  logic        mthiE,
    input  logic        mtloE,
    input  logic [31:0] wdataE,
    input  logic        cancel,
    output logic        stallE,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mdBusy,
    output logic        mdDone
);
    md_state_t   state;
    logic [4:0]  cnt;
    logic        a_neg, b_neg;
    logic [31:0] part_hi, part_lo, mag_b;
    logic [31:0] nxt_hi, nxt_lo;
    logic [31:0] res_hi, res_lo;
    logic [63:0] prod;
    logic        signed_op, op_ok, start_go;
`ifdef MD_DIV_EN
    logic        div_q, b_zero;
`endif

    assign signed_op = (mdOpE == MD_MULT) || (mdOpE == MD_DIV);
`ifdef MD_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (mdOpE == MD_MULT) || (mdOpE == MD_MULTU);
`endif
    assign start_go = startE && !cancel && op_ok;

    assign mdBusy = (state != ST_IDLE);
    assign stallE = (startE | mfE | mthiE | mtloE) & (state != ST_IDLE);
    assign mdDone = (state == ST_DONE) && !cancel;

    md_iter u_iter (
`ifdef MD_DIV_EN
        .is_div (div_q),
`endif
        .hi_in  (part_hi),
        .lo_in  (part_lo),
        .b_in   (mag_b),
        .hi_out (nxt_hi),
        .lo_out (nxt_lo)
    );

    // Sign fix: product negated as a whole; quotient takes xor of signs, remainder the dividend's.
    always_comb begin
        prod   = (a_neg ^ b_neg) ? -{part_hi, part_lo} : {part_hi, part_lo};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MD_DIV_EN
        if (div_q) begin
            res_lo = b_zero ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? -part_lo : part_lo);
            res_hi = a_neg ? -part_hi : part_hi;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 5'd0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            part_hi <= 32'd0;
            part_lo <= 32'd0;
            mag_b   <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
`ifdef MD_DIV_EN
            div_q   <= 1'b0;
            b_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        a_neg   <= signed_op & srcAE[31];
                        b_neg   <= signed_op & srcBE[31];
                        part_hi <= 32'd0;
                        part_lo <= abs32(srcAE, signed_op & srcAE[31]);
                        mag_b   <= abs32(srcBE, signed_op & srcBE[31]);
                        cnt     <= 5'd0;
                        state   <= ST_BUSY;
`ifdef MD_DIV_EN
                        div_q   <= mdOpE[1];
                        b_zero  <= (srcBE == 32'd0);
`endif
                    end else if (!startE) begin
                        if (mthiE) hi <= wdataE;
                        if (mtloE) lo <= wdataE;
                    end
                end
                ST_BUSY: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        part_hi <= nxt_hi;
                        part_lo <= nxt_lo;
                        cnt     <= cnt + 5'd1;
                        if (cnt == 5'(MD_ITER - 1)) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!cancel) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 startE  input  1  mult/div instruction valid in EX this cycle.
REQ-005 mdOpE  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srcAE / srcBE  input  32 each  forwarded EX operands (rs, rt).
REQ-007 mfE  input  1  MFHI/MFLO in EX.
REQ-008 mthiE / mtloE  input  1 each  MTHI/MTLO in EX.
REQ-009 wdataE  input  32  MTHI/MTLO write data.
REQ-010 cancel  input  1  abort the in-flight operation.
REQ-011 stallE  output  1  freeze IF/ID/EX this cycle.
REQ-012 hi / lo  output  32 each  HI/LO architectural registers.
REQ-013 mdBusy  output  1  state != IDLE.
REQ-014 mdDone  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and DONE.
REQ-016 In IDLE, startE SHALL capture operand magnitudes, operand signs and the op, clear the iteration counter, and enter BUSY.
REQ-017 BUSY SHALL run exactly 32 single-bit iterations: shift-add for multiply, restoring subtract for divide; after count 31 the FSM enters DONE.
REQ-018 DONE SHALL apply the sign fix, write HI/LO on its closing edge, assert mdDone, and return to IDLE.
REQ-019 Latency: startE sampled at edge T; BUSY T+1..T+32; DONE T+33; new HI/LO visible from T+34.
REQ-020 MULT/MULTU: the SHALL be {HI,LO} = 64-bit product (signed or unsigned).
REQ-021 DIV/DIVU: LO SHALL be the quotient truncated toward zero and HI the remainder; the remainder takes the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divisor zero (DIV or DIVU) SHALL give LO=0xFFFFFFFF, HI=srcAE after the full 34-cycle latency.
REQ-024 stallE SHALL equal (startE | mfE | mthiE | mtloE) & (state != IDLE); the multiply/divide instruction itself never stalls in IDLE.
REQ-025 mthiE/mtloE in IDLE SHALL write wdataE to hi/lo on the next edge; when both are asserted, both registers are written.
REQ-026 If startE and mthiE/mtloE are asserted together, startE SHALL win and the move is ignored.
REQ-027 cancel in BUSY or DONE SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged, and suppress mdDone; cancel takes priority over DONE's write.
REQ-028 cancel in IDLE SHALL have no effect; cancel with startE in IDLE SHALL suppress the start.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, stallE=0, mdBusy=0, mdDone=0, even mid-operation.
REQ-030 Internal operand and partial registers SHALL reset to 0.

Configuration
REQ-031 Macro MD_DIV_EN defined: DIV/DIVU SHALL be supported per REQ-021..023.
REQ-032 Macro MD_DIV_EN undefined: the divide datapath SHALL be absent; startE with mdOpE[1]=1 is ignored (no state change, no stall, HI/LO unchanged).

Structure
REQ-033 The shared package/defines header SHALL hold the MD_MULT/MD_MULTU/MD_DIV/MD_DIVU encodings, MD_ITER=32, and the FSM state encodings.
REQ-034 The per-iteration add/subtract-shift step SHALL live in one sub-module, md_iter; md_ctrl holds the FSM, counter, sign logic and HI/LO.

Verification
REQ-035 MULT 0xFFFFFFFF*0x00000002 -> from T+34 HI=0xFFFFFFFF, LO=0xFFFFFFFE; mdDone high only at T+33.
REQ-036 MULTU 0xFFFFFFFF*0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-037 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-038 MULT at T, mfE held from T+1 -> stallE=1 for T+1..T+33, 0 at T+34 with the new HI visible; mfE at T alone -> stallE=0.
REQ-039 Divide started, cancel at T+10 -> IDLE at T+11, HI/LO keep prior values, no mdDone; rst_n pulsed low at T+5 of another op -> hi=lo=0 and IDLE immediately.
REQ-040 Build without MD_DIV_EN, DIV issued -> mdBusy stays 0 and HI/LO unchanged.
